// File: rtl/wb_bridge_pkg.sv
// rtl/wb_bridge_pkg.sv - shared types and helpers for the Wishbone/core bridges
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } bridge_state_t;

    // Bits needed to hold 0..max_outstanding inclusive.
    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/outstanding_ctr.sv
// rtl/outstanding_ctr.sv - saturating up/down counter of in-flight requests
module outstanding_ctr #(
    parameter int MAX = 2,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_next,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] cnt;
    logic         up;
    logic         dn;

    // Flags come from the registered count only, so a response in this
    // cycle never frees a slot for a request in the same cycle.
    assign full  = (cnt == W'(MAX));
    assign empty = (cnt == '0);

    // Saturate at both ends: a stray decrement at zero is ignored.
    assign up = inc & ~full;
    assign dn = dec & ~empty;

    // Next count; simultaneous up and down cancel out.
    always_comb begin
        cnt_next = cnt;
        if (up && !dn) begin
            cnt_next = cnt + W'(1);
        end else if (!up && dn) begin
            cnt_next = cnt - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/wb2core.sv
// rtl/wb2core.sv - pipelined Wishbone slave driving a core-style request port
module wb2core
    import wb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_stall,
    output logic                    core_req,
    input  logic                    core_gnt,
    output logic                    core_we,
    output logic [DATA_WIDTH/8-1:0] core_be,
    output logic [ADDR_WIDTH-1:0]   core_addr,
    output logic [DATA_WIDTH-1:0]   core_wdata,
    input  logic                    core_rvalid,
    input  logic [DATA_WIDTH-1:0]   core_rdata,
    input  logic                    core_err
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);

    bridge_state_t state;
    bridge_state_t state_next;
    logic [CW-1:0] cnt_next;
    logic          full;
    logic          empty;
    logic          accept;
    logic          rv_counted;
    logic          rsp_live;

    // The master holds its request stable while stalled, so the core-side
    // hold rule is met by passing the request fields straight through.
    assign core_we    = wb_we;
    assign core_be    = wb_sel;
    assign core_addr  = wb_adr;
    assign core_wdata = wb_dat_i;

    // No new requests while full or while draining orphaned responses.
    assign core_req = wb_cyc & wb_stb & ~full & (state != DRAIN);
    assign accept   = core_req & core_gnt;
    assign wb_stall = ~accept;

    // A response only counts if something is actually outstanding; it is
    // forwarded only if its cycle is still alive.
    assign rv_counted = core_rvalid & ~empty;
    assign rsp_live   = rv_counted & wb_cyc & (state != DRAIN);

    outstanding_ctr #(
        .MAX (MAX_OUTSTANDING),
        .W   (CW)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (accept),
        .dec      (core_rvalid),
        .cnt_next (cnt_next),
        .full     (full),
        .empty    (empty)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: drop to DRAIN if the master abandons its cycle with
    // responses still owed, return to IDLE once nothing is outstanding.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_next == '0) begin
                    state_next = IDLE;
                end else if (!wb_cyc) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered response: one cycle after core_rvalid; data captured on any
    // counted response and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack <= rsp_live & ~core_err;
            wb_err <= rsp_live & core_err;
            if (rv_counted) begin
                wb_dat_o <= core_rdata;
            end
        end
    end

endmodule

// File: doc/wb2core.md
Name: wb2core

Overview:
- Bridge from the Wishbone bus to the Ibex-style core request interface, converting in the opposite direction to the existing core-to-Wishbone bridge.
- Acts as a pipelined Wishbone slave and drives a core-style initiator port (req/gnt/rvalid/err) into memories and peripherals that expose the core interface.
- Tracks outstanding transactions, registers responses, and discards the responses of transactions orphaned by an early cyc drop.
- Reset is asynchronous and active-high.

Parameters:
ADDR_WIDTH, 32, width of wb_adr/core_addr
DATA_WIDTH, 32, width of data buses; byte enables are DATA_WIDTH/8
MAX_OUTSTANDING, 2, maximum number of accepted requests awaiting core_rvalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_cyc  in  1  Wishbone cycle
wb_stb  in  1  Wishbone strobe
wb_we  in  1  write enable
wb_adr  in  ADDR_WIDTH  address
wb_sel  in  DATA_WIDTH/8  byte select
wb_dat_i  in  DATA_WIDTH  write data from master
wb_dat_o  out  DATA_WIDTH  read data to master (registered)
wb_ack  out  1  acknowledge (registered)
wb_err  out  1  error (registered)
wb_stall  out  1  pipelined stall
core_req  out  1  request
core_gnt  in  1  grant
core_we  out  1  write enable (= wb_we)
core_be  out  DATA_WIDTH/8  byte enables (= wb_sel)
core_addr  out  ADDR_WIDTH  address (= wb_adr)
core_wdata  out  DATA_WIDTH  write data (= wb_dat_i)
core_rvalid  in  1  response valid
core_rdata  in  DATA_WIDTH  response data
core_err  in  1  response error, qualified by core_rvalid

Behaviour:
- Reset values: wb_ack=0, wb_err=0, wb_dat_o=0, cnt=0, state=IDLE.
- State machine:
  - IDLE: cnt==0.
  - ACTIVE: cnt>0 and wb_cyc=1.
  - DRAIN: wb_cyc fell while responses are still owed.
- Request path:
  - core_req = wb_cyc & wb_stb & ~full & (state!=DRAIN), where full = (cnt==MAX_OUTSTANDING).
  - Address, data, we and be pass through combinationally.
  - accept = core_req & core_gnt.
  - wb_stall = ~accept. The master holds its request stable while stalled, which satisfies the core-side hold rule.
- Counter: cnt_next = cnt + accept - (core_rvalid & cnt!=0).
  - Simultaneous accept and rvalid leaves cnt unchanged.
  - full is evaluated on registered cnt only, so there is no same-cycle bypass.
- Response path, registered, 1-cycle latency after core_rvalid:
  - wb_ack <= core_rvalid & ~core_err & wb_cyc & state!=DRAIN & cnt!=0
  - wb_err <= same terms, with core_err in place of ~core_err
  - wb_dat_o <= core_rdata on any counted core_rvalid; held otherwise.
- Transitions:
  - IDLE->ACTIVE on accept.
  - ACTIVE->IDLE when cnt_next==0.
  - ACTIVE->DRAIN when wb_cyc=0 and cnt_next>0.
  - DRAIN->IDLE when cnt_next==0.
  - IDLE with wb_cyc=0: stay.
- DRAIN:
  - core_req=0 and wb_stall=1, including when wb_cyc is reasserted.
  - core_rvalid is consumed with no wb_ack/wb_err.
  - A new cycle proceeds from IDLE.
- Boundaries:
  - wb_cyc falling in the same cycle as core_rvalid: that response is dropped, no ack next cycle.
  - core_rvalid with cnt==0 is a protocol violation: ignored, no underflow, no ack.
  - wb_stb while full: stalled, core_req=0.
  - Reset mid-transaction: all state clears at once and late core_rvalid is ignored (cnt==0).

Decomposition:
- Shared package wb_bridge_pkg holds:
  - typedef enum {IDLE, ACTIVE, DRAIN} bridge_state_t
  - function cnt_width(MAX_OUTSTANDING) returning $clog2(MAX_OUTSTANDING+1)
- One natural sub-module, outstanding_ctr: saturating up/down counter with full/empty flags, parameterised by MAX.

Test Plan:
- Single read: wb_adr=0x100, gnt same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF -> stall=0 on accept, wb_ack=1 with wb_dat_o=0xDEADBEEF exactly 1 cycle after rvalid, cnt returns to 0.
- Back-to-back with MAX_OUTSTANDING=2: 3 stb beats, responses delayed -> beats 1-2 accepted, beat 3 stalled until the first rvalid, then accepted; 3 acks in order.
- Error: write 0x12345678 to 0x200 with be=0b0011, rvalid+core_err=1 -> wb_err=1, wb_ack=0 for one cycle.
- Abort: 2 accepted, wb_cyc dropped, then cyc reasserted with stb -> state DRAIN, no acks for the 2 rvalids, stall=1 until cnt=0, then the new request is accepted.
- Edges: spurious core_rvalid at cnt=0 -> no ack and cnt stays 0; rst asserted with cnt=2 -> all outputs 0 asynchronously, later rvalids ignored.
